jet_feature_bn_loader: RTL and testbench

Upstream input stage of the jet-tagging network. Accepts the 16 raw jet features as a serial valid/ready stream, applies per-feature batch-normalisation (fixed-point scale and bias, rounded and saturated), and assembles them into a double-buffered parallel vector. When a frame is complete it presents the vector on `output_data` and pulses `output_ready`. These two outputs drive the first dense layer's `input_data` / `input_ready` directly.

---
 rtl/jet_feature_bn_loader.sv | 208 ++++++++++++++++++++
 tb/tb_jet_feature_bn_loader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jet_feature_bn_loader.sv
// ---------------------------------------------------------------------------
// jet_feature_bn_loader
//
// Input stage of the jet-tagging network. Raw jet features arrive one per
// beat on a valid/ready stream. Each beat is batch-normalised with its own
// fixed-point scale and bias, rounded half-up, saturated to WIDTH bits and
// written into a staging bank. When the last beat of a frame has been taken,
// the staging bank is copied into a separate output bank. output_ready then
// pulses for one cycle to tell the first dense layer that a new vector is
// available.
//
// Parameters:
//   WIDTH       data width (signed fixed point)
//   NFRAC       fractional bits shared by data, scale and bias
//   N_FEATURES  features per frame
//   SCALE/BIAS  per-feature multiplier / offset, indexed by beat position
//   FRAME_GAP   idle cycles forced after each emitted frame
//
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   s_valid       feature beat valid
//   s_ready       beat accepted when s_valid && s_ready (registered)
//   s_data        raw feature, signed
//   s_last        marks the final beat of a frame
//   output_data   normalised vector, element k = beat k (held between frames)
//   output_ready  one-cycle pulse when output_data has been updated
//   sat_flag      valid with output_ready: some feature of the frame clamped
//   frame_err     one-cycle pulse on a framing error
//
// Optional feature: define BN_LAST_CHECK_EN to check s_last against the
// beat counter. Without it, s_last is ignored and frame_err is tied to 0.
// ---------------------------------------------------------------------------
module jet_feature_bn_loader #(
  parameter int WIDTH      = 16,
  parameter int NFRAC      = 10,
  parameter int N_FEATURES = 16,
  parameter logic signed [WIDTH-1:0] SCALE [N_FEATURES-1:0] = '{default: WIDTH'(1 << NFRAC)},
  parameter logic signed [WIDTH-1:0] BIAS  [N_FEATURES-1:0] = '{default: '0},
  parameter int FRAME_GAP  = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic signed [WIDTH-1:0]            s_data,
  input  logic                               s_last,
  output logic [N_FEATURES-1:0][WIDTH-1:0]   output_data,
  output logic                               output_ready,
  output logic                               sat_flag,
  output logic                               frame_err
);

  localparam int IDX_W = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;
  localparam int GAP_W = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
  localparam int PW    = 2 * WIDTH;

  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(N_FEATURES - 1);
  localparam logic signed [PW-1:0] ROUND_HALF = PW'(1 << (NFRAC - 1));
  localparam logic signed [PW-1:0] SAT_MAX    = PW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  // Bitwise inverse of 0..0111..1 is 1..1000..0, the most negative WIDTH value.
  localparam logic signed [PW-1:0] SAT_MIN    = ~SAT_MAX;

  typedef enum logic [1:0] {
    COLLECT,
    EMIT,
    GAP
  } state_t;

  state_t                            state, state_next;
  logic [IDX_W-1:0]                  idx, idx_next;
  logic [GAP_W-1:0]                  gap_cnt;
  logic                              sat_acc, sat_acc_next;
  logic                              err_next;
  logic [N_FEATURES-1:0][WIDTH-1:0]  staging;

  logic                              accept;
  logic                              at_last;
  logic signed [WIDTH-1:0]           scale_sel, bias_sel;
  logic signed [PW-1:0]              prod, sum;
  logic signed [WIDTH-1:0]           beat_norm;
  logic                              beat_sat;

  // s_ready is only ever high in COLLECT, so a handshake implies COLLECT.
  assign accept  = s_valid && s_ready;
  assign at_last = (idx == LAST_IDX);

  // -------------------------------------------------------------------------
  // Per-beat normalisation: full-width product, add half an LSB, arithmetic
  // shift (floor) gives half-up rounding, then bias and clamp.
  // -------------------------------------------------------------------------
  always_comb begin
    scale_sel = SCALE[idx];
    bias_sel  = BIAS[idx];
    prod      = PW'(s_data) * PW'(scale_sel);
    sum       = ((prod + ROUND_HALF) >>> NFRAC) + PW'(bias_sel);
    // NOTE: every always_comb output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    beat_sat  = 1'b0;
    beat_norm = sum[WIDTH-1:0];
    if (sum > SAT_MAX) begin
      beat_norm = SAT_MAX[WIDTH-1:0];
      beat_sat  = 1'b1;
    end else if (sum < SAT_MIN) begin
      beat_norm = SAT_MIN[WIDTH-1:0];
      beat_sat  = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state, beat counter and saturation accumulator.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    sat_acc_next = sat_acc;
    err_next     = 1'b0;
    unique case (state)
      COLLECT: begin
        if (accept) begin
          sat_acc_next = sat_acc | beat_sat;
          if (at_last) begin
            idx_next   = '0;
            state_next = EMIT;
          end else begin
            idx_next   = idx + IDX_W'(1);
          end
`ifdef BN_LAST_CHECK_EN
          // Early s_last: drop the partial frame and start over at beat 0.
          if (s_last && !at_last) begin
            idx_next     = '0;
            sat_acc_next = 1'b0;
            err_next     = 1'b1;
          end
          // Missing s_last on the final beat: flag it but still emit.
          if (!s_last && at_last) begin
            err_next = 1'b1;
          end
`endif
        end
      end
      EMIT: begin
        sat_acc_next = 1'b0;
        state_next   = (FRAME_GAP > 0) ? GAP : COLLECT;
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state        <= COLLECT;
      idx          <= '0;
      gap_cnt      <= '0;
      sat_acc      <= 1'b0;
      s_ready      <= 1'b0;
      output_ready <= 1'b0;
      sat_flag     <= 1'b0;
      // NOTE: both banks are cleared on reset so a reset mid-frame leaves no
      // stale features visible downstream; they are flops, not RAM.
      staging      <= '0;
      output_data  <= '0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      sat_acc      <= sat_acc_next;
      s_ready      <= (state_next == COLLECT);
      output_ready <= (state == EMIT);

      if (accept) begin
        staging[idx] <= beat_norm;
      end

      if (state == EMIT) begin
        output_data <= staging;
        sat_flag    <= sat_acc;
        gap_cnt     <= GAP_W'(FRAME_GAP);
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

`ifdef BN_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_next;
    end
  end
`else
  // Framing relies on the beat counter alone; s_last has no effect.
  logic unused_framing;
  assign unused_framing = s_last | err_next;
  assign frame_err      = 1'b0;
`endif

endmodule

// File: tb/tb_jet_feature_bn_loader.sv
// ---------------------------------------------------------------------------
// tb_jet_feature_bn_loader
//
// Two loader instances share clk/reset:
//   dut 0: FRAME_GAP=0, SCALE[0]=2048, all other scale 1.0, no bias
//   dut 1: FRAME_GAP=3, SCALE[0]=0.5,  BIAS[1]=1.0
// A frame-level model predicts s_ready, output_ready, output_data, sat_flag
// and frame_err for every cycle. A compare process checks them on each
// falling edge. Directed tests add literal expectations worked out by hand.
// ---------------------------------------------------------------------------
module tb_jet_feature_bn_loader;

  localparam int W  = 16;
  localparam int NF = 16;

  typedef logic signed [W-1:0] coef_t [NF-1:0];

  localparam coef_t SCALE_A = '{0: 16'sd2048, default: 16'sd1024};
  localparam coef_t BIAS_A  = '{default: 16'sd0};
  localparam coef_t SCALE_B = '{0: 16'sd512, default: 16'sd1024};
  localparam coef_t BIAS_B  = '{1: 16'sd1024, default: 16'sd0};
  localparam int    GAP_A   = 0;
  localparam int    GAP_B   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic                 s_valid      [2];
  logic                 s_ready      [2];
  logic [W-1:0]         s_data       [2];
  logic                 s_last       [2];
  logic [NF-1:0][W-1:0] output_data  [2];
  logic                 output_ready [2];
  logic                 sat_flag     [2];
  logic                 frame_err    [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  jet_feature_bn_loader #(
    .WIDTH(W), .NFRAC(10), .N_FEATURES(NF),
    .SCALE(SCALE_A), .BIAS(BIAS_A), .FRAME_GAP(GAP_A)
  ) u_a (
    .clk(clk), .reset(reset),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
    .output_data(output_data[0]), .output_ready(output_ready[0]),
    .sat_flag(sat_flag[0]), .frame_err(frame_err[0])
  );

  jet_feature_bn_loader #(
    .WIDTH(W), .NFRAC(10), .N_FEATURES(NF),
    .SCALE(SCALE_B), .BIAS(BIAS_B), .FRAME_GAP(GAP_B)
  ) u_b (
    .clk(clk), .reset(reset),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
    .output_data(output_data[1]), .output_ready(output_ready[1]),
    .sat_flag(sat_flag[1]), .frame_err(frame_err[1])
  );

  task automatic check(input string name, input int d,
                       input logic [NF*W-1:0] act, input logic [NF*W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
  endtask

  // -------------------------------------------------------------------------
  // Model: y = clamp(floor((x*scale + 512) / 1024) + bias, -32768, 32767).
  // -------------------------------------------------------------------------
  function automatic int norm(input int d, input int k, input int x, output bit sat);
    int     sc = (d == 0) ? int'(SCALE_A[k]) : int'(SCALE_B[k]);
    int     bi = (d == 0) ? int'(BIAS_A[k])  : int'(BIAS_B[k]);
    longint prod, s;
    prod = longint'(x) * longint'(sc);
    s    = ((prod + 512) >>> 10) + longint'(bi);
    sat  = 1'b0;
    if (s > 32767) begin
      sat = 1'b1;
      return 32767;
    end
    if (s < -32768) begin
      sat = 1'b1;
      return -32768;
    end
    return int'(s);
  endfunction

  bit m_ready     [2];
  int m_cnt       [2];
  int m_block     [2];
  bit m_emit_pend [2];
  bit m_sat_acc   [2];
  bit m_frame_sat [2];
  bit m_or        [2];
  bit m_sat       [2];
  bit m_err       [2];
  int m_stage     [2][NF];
  int m_out       [2][NF];

  int m_v;
  bit m_bsat;
  bit m_early;

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_ready[d]     = 1'b0;
        m_cnt[d]       = 0;
        m_block[d]     = 0;
        m_emit_pend[d] = 1'b0;
        m_sat_acc[d]   = 1'b0;
        m_frame_sat[d] = 1'b0;
        m_or[d]        = 1'b0;
        m_sat[d]       = 1'b0;
        m_err[d]       = 1'b0;
        for (int k = 0; k < NF; k++) begin
          m_stage[d][k] = 0;
          m_out[d][k]   = 0;
        end
      end else begin
        m_or[d]  = 1'b0;
        m_err[d] = 1'b0;
        if (m_emit_pend[d]) begin
          for (int k = 0; k < NF; k++) m_out[d][k] = m_stage[d][k];
          m_or[d]        = 1'b1;
          m_sat[d]       = m_frame_sat[d];
          m_emit_pend[d] = 1'b0;
        end
        if (m_block[d] > 0) m_block[d]--;
        if (s_valid[d] && m_ready[d]) begin
          m_v     = norm(d, m_cnt[d], int'($signed(s_data[d])), m_bsat);
          m_stage[d][m_cnt[d]] = m_v;
          m_early = 1'b0;
`ifdef BN_LAST_CHECK_EN
          if (s_last[d] && m_cnt[d] < NF - 1) m_early = 1'b1;
          if (m_early || (!s_last[d] && m_cnt[d] == NF - 1)) m_err[d] = 1'b1;
`endif
          if (m_early) begin
            m_cnt[d]     = 0;
            m_sat_acc[d] = 1'b0;
          end else begin
            m_sat_acc[d] = m_sat_acc[d] | m_bsat;
            if (m_cnt[d] == NF - 1) begin
              m_cnt[d]       = 0;
              m_emit_pend[d] = 1'b1;
              m_frame_sat[d] = m_sat_acc[d];
              m_sat_acc[d]   = 1'b0;
              m_block[d]     = 1 + ((d == 0) ? GAP_A : GAP_B);
            end else begin
              m_cnt[d]++;
            end
          end
        end
        m_ready[d] = (m_block[d] == 0);
      end
    end
  end

  // Compare process: every cycle, both instances.
  logic [NF-1:0][W-1:0] ev;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NF; k++) ev[k] = W'(m_out[d][k]);
      check("s_ready", d, s_ready[d], m_ready[d]);
      check("output_ready", d, output_ready[d], m_or[d]);
      check("frame_err", d, frame_err[d], m_err[d]);
      check("output_data", d, output_data[d], ev);
      if (m_or[d]) check("sat_flag", d, sat_flag[d], m_sat[d]);
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int frame_buf [NF];

  task automatic send_beat(input int d, input int v, input bit last, output int acc_cyc);
    int n;
    @(negedge clk);
    s_valid[d] = 1'b1;
    s_data[d]  = W'(v);
    s_last[d]  = last;
    n = 0;
    while (s_ready[d] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("beat_accept_timeout", d, 1'b0, 1'b1);
    acc_cyc = cyc;
  endtask

  task automatic send_frame(input int d, input int n, input int last_pos,
                            output int t_first, output int t_last);
    t_first = 0;
    t_last  = 0;
    for (int k = 0; k < n; k++) begin
      send_beat(d, frame_buf[k], (k == last_pos), t_last);
      if (k == 0) t_first = t_last;
    end
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
  endtask

  task automatic wait_or(input int d);
    int n = 0;
    while (output_ready[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("output_ready_seen", d, output_ready[d], 1'b1);
  endtask

  int t_first, t_last, t1, t2;

  initial begin
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0;
      s_data[d]  = '0;
      s_last[d]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_s_ready", 0, s_ready[0], 1'b0);
    check("rst_output_data", 1, output_data[1], '0);
    reset = 1'b0;

    // Identity: beats k*64 on dut 0 (beat 0 is zero, so its 2x scale is moot).
    for (int k = 0; k < NF; k++) frame_buf[k] = k * 64;
    send_frame(0, NF, NF - 1, t_first, t_last);
    @(negedge clk);
    s_valid[0] = 1'b0;
    s_last[0]  = 1'b0;
    check("ident_or_t1", 0, output_ready[0], 1'b0);
    @(negedge clk);
    check("ident_or_t2", 0, output_ready[0], 1'b1);
    check("ident_sat", 0, sat_flag[0], 1'b0);
    check("ident_d5", 0, output_data[0][5], 16'd320);
    check("ident_d15", 0, output_data[0][15], 16'd960);

    // Saturation: 0x7000 * 2.0 clamps high, -0x7000 * 2.0 clamps low.
    for (int k = 0; k < NF; k++) frame_buf[k] = k;
    frame_buf[0] = 28672;
    send_frame(0, NF, NF - 1, t_first, t_last);
    idle(0);
    wait_or(0);
    check("sat_hi_d0", 0, output_data[0][0], 16'h7FFF);
    check("sat_hi_flag", 0, sat_flag[0], 1'b1);
    frame_buf[0] = -28672;
    send_frame(0, NF, NF - 1, t_first, t_last);
    idle(0);
    wait_or(0);
    check("sat_lo_d0", 0, output_data[0][0], 16'h8000);
    check("sat_lo_flag", 0, sat_flag[0], 1'b1);
    check("sat_lo_d7", 0, output_data[0][7], 16'd7);

`ifdef BN_LAST_CHECK_EN
    // Early s_last on beat 5: error pulse, frame discarded.
    for (int k = 0; k < NF; k++) frame_buf[k] = k * 5;
    send_frame(0, 6, 5, t_first, t_last);
    @(negedge clk);
    s_valid[0] = 1'b0;
    s_last[0]  = 1'b0;
    check("early_last_err", 0, frame_err[0], 1'b1);
    send_frame(0, NF, NF - 1, t_first, t_last);
    idle(0);
    wait_or(0);
    check("after_err_d15", 0, output_data[0][15], 16'd75);
    check("after_err_d5", 0, output_data[0][5], 16'd25);
    // Missing s_last on beat 15: error pulse, frame still emitted.
    for (int k = 0; k < NF; k++) frame_buf[k] = k * 7;
    send_frame(0, NF, -1, t_first, t_last);
    @(negedge clk);
    s_valid[0] = 1'b0;
    check("missing_last_err", 0, frame_err[0], 1'b1);
    wait_or(0);
    check("missing_last_d3", 0, output_data[0][3], 16'd21);
`endif

    // Rounding and bias on dut 1, then back-to-back frame against the gap.
    for (int k = 0; k < NF; k++) frame_buf[k] = k * 10;
    frame_buf[0] = 3;
    frame_buf[1] = 0;
    send_frame(1, NF, NF - 1, t_first, t1);
    for (int k = 0; k < NF; k++) frame_buf[k] = k * 20;
    frame_buf[0] = -3;
    frame_buf[1] = 0;
    send_frame(1, NF, NF - 1, t2, t_last);
    check("gap_first_accept", 1, t2 - t1, 32'd5);
    check("held_round_pos", 1, output_data[1][0], 16'd2);
    check("held_bias", 1, output_data[1][1], 16'd1024);
    idle(1);
    wait_or(1);
    check("round_neg", 1, output_data[1][0], 16'hFFFF);
    check("bias2", 1, output_data[1][1], 16'd1024);
    check("round_d4", 1, output_data[1][4], 16'd80);

    // Reset after 7 beats: partial frame lost, outputs cleared.
    for (int k = 0; k < NF; k++) frame_buf[k] = 500 + k;
    send_frame(1, 7, -1, t_first, t_last);
    idle(1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_s_ready", 1, s_ready[1], 1'b0);
    check("mid_rst_data", 1, output_data[1], '0);
    check("mid_rst_or", 1, output_ready[1], 1'b0);
    reset = 1'b0;
    for (int k = 0; k < NF; k++) frame_buf[k] = 100 + k;
    send_frame(1, NF, NF - 1, t_first, t_last);
    idle(1);
    wait_or(1);
    check("post_rst_d0", 1, output_data[1][0], 16'd50);
    check("post_rst_d1", 1, output_data[1][1], 16'd1125);
    check("post_rst_d2", 1, output_data[1][2], 16'd102);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
